// File: rtl/checked_delay_pipe.sv
// Stallable, flushable WIDTH x DEPTH register pipeline with valid bits and an occupancy count.
// Define CHECKED_DELAY_PIPE_SVA_EN to embed latency/integrity assertions (no effect on function).
module checked_delay_pipe #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       CLK,
  input  logic                       ASYNCRESETN,
  input  logic [WIDTH-1:0]           I,
  input  logic                       I_valid,
  input  logic                       CE,
  input  logic                       FLUSH,
  output logic [WIDTH-1:0]           O,
  output logic                       O_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OccW-1:0]  occ_q, occ_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;

    // Data moves on CE even during a flush; only the valid bits are cleared.
    if (CE) begin
      data_d[0] = I;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        data_d[k] = data_q[k-1];
      end
    end

    if (FLUSH) begin
      valid_d = '0;
      occ_d   = '0;
    end else if (CE) begin
      valid_d[0] = I_valid;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
      end
      occ_d = occ_q + OccW'(I_valid) - OccW'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_q[k] <= RESET_VALUE;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign O         = data_q[DEPTH-1];
  assign O_valid   = valid_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef CHECKED_DELAY_PIPE_SVA_EN
  // Consecutive enabled, non-flushing edges, saturating at DEPTH.
  logic [OccW-1:0] run_q;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      run_q <= '0;
    end else if (FLUSH || !CE) begin
      run_q <= '0;
    end else if (run_q != OccW'(DEPTH)) begin
      run_q <= run_q + OccW'(1);
    end
  end

  a_occ_popcount: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    occ_q == OccW'($countones(valid_q)))
    else $error("a_occ_popcount: occupancy differs from popcount(valid)");

  a_occ_bound: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    occ_q <= OccW'(DEPTH))
    else $error("a_occ_bound: occupancy exceeds DEPTH");

  a_flush_empties: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    FLUSH |=> (occ_q == '0) && !O_valid)
    else $error("a_flush_empties: pipe not empty after FLUSH");

  a_stall_holds: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    (!CE && !FLUSH) |=> $stable(O) && $stable(O_valid) && $stable(occ_q))
    else $error("a_stall_holds: outputs changed while stalled");

  a_latency_data: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
    (run_q == OccW'(DEPTH) && $past(I_valid, DEPTH)) |-> (O_valid && O == $past(I, DEPTH)))
    else $error("a_latency_data: word did not emerge intact after DEPTH enabled edges");
`endif

endmodule
